// File: rtl/wb_slave_responder.sv
// Wishbone classic-cycle responder with a CTRL/STATUS/DATA/SCRATCH byte map and a TX FIFO drained by a local valid/ready port.
// Optional build macro WB_RESP_ERR_EN: an overflowing DATA write terminates with err_o instead of ack_o.
module wb_slave_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  SCRATCH_RST = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       err_o,
  output logic       irq_o,
  output logic       loc_valid_o,
  output logic [7:0] loc_data_o,
  input  logic       loc_ready_i
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_DATA = 2'd2, A_SCRATCH = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } wb_req_t;

  state_t  state_q, state_d;
  wb_req_t req_q, req_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic resp;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wcnt_d  = wcnt_q;
    resp    = 1'b0;
    case (state_q)
      S_IDLE: if (cyc_i && stb_i) begin
        req_d = '{we: we_i, adr: adr_i, dat: dat_i};
        if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_STATES - 1);
        end else begin
          state_d = S_RESP;
        end
      end
      // an abandoned cycle returns quietly; nothing has committed yet
      S_WAIT: begin
        if (!(cyc_i && stb_i))  state_d = S_IDLE;
        else if (wcnt_q == '0) state_d = S_RESP;
        else                   wcnt_d  = wcnt_q - 4'd1;
      end
      S_RESP: begin
        resp    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [6:0] ctrl_q;
  logic [7:0] scratch_q;
  logic ovf_q, irq_q;
  logic full, empty, wr_commit, data_wr, push, pop, ovf_wr, flush, rd_status;
  logic [7:0] status, rdata;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign wr_commit = resp & req_q.we;
  assign data_wr   = wr_commit & (req_q.adr == A_DATA);
  assign push      = data_wr & ~full;
  assign ovf_wr    = data_wr & full;
  assign flush     = wr_commit & (req_q.adr == A_CTRL) & req_q.dat[7];
  assign rd_status = resp & ~req_q.we & (req_q.adr == A_STATUS);
  assign pop       = loc_valid_o & loc_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ctrl_q    <= '0;
      scratch_q <= SCRATCH_RST;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      // flush overrides any coincident push or pop
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (wr_commit && req_q.adr == A_CTRL)    ctrl_q    <= req_q.dat[6:0];
      if (wr_commit && req_q.adr == A_SCRATCH) scratch_q <= req_q.dat;
      if (ovf_wr)         ovf_q <= 1'b1;
      else if (rd_status) ovf_q <= 1'b0;
      irq_q <= ctrl_q[1] & empty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= req_q.dat;
  end

  assign status = {ovf_q, 1'b0, full, empty, 4'(count)};

  always_comb begin
    rdata = '0;
    case (req_q.adr)
      A_CTRL:    rdata = {1'b0, ctrl_q};
      A_STATUS:  rdata = status;
      A_DATA:    rdata = '0;
      A_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end

`ifdef WB_RESP_ERR_EN
  assign err_o = ovf_wr;
  assign ack_o = resp & ~ovf_wr;
`else
  assign err_o = 1'b0;
  assign ack_o = resp;
`endif

  assign dat_o       = ack_o ? rdata : '0;
  assign irq_o       = irq_q;
  assign loc_valid_o = ~empty & ctrl_q[0];
  assign loc_data_o  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_wb_slave_responder.sv
// Directed plus randomized bench for wb_slave_responder against a queue-based register/FIFO model.
module tb_wb_slave_responder;
  localparam int NDUT = 3;
  localparam logic [NDUT-1:0][3:0] WS_TAB = {4'd5, 4'd3, 4'd0};
  localparam int MD = 2;
  localparam int DEPTH = 4;
  localparam int MLAT = 6;
  localparam logic [7:0] M_SCR_RST = 8'h3C;
`ifdef WB_RESP_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NDUT-1:0] cyc = '0, stb = '0, we = '0, lr = '0;
  logic [NDUT-1:0][1:0] adr = '0;
  logic [NDUT-1:0][7:0] wdat = '0;
  logic [NDUT-1:0][7:0] dat_o, ld;
  logic [NDUT-1:0] ack, err, irq, lv;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_slave_responder #(
      .WAIT_STATES(int'(WS_TAB[g])),
      .FIFO_DEPTH (DEPTH),
      .SCRATCH_RST((g == MD) ? M_SCR_RST : 8'h00)
    ) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[g]), .stb_i(stb[g]), .we_i(we[g]),
      .adr_i(adr[g]), .dat_i(wdat[g]), .dat_o(dat_o[g]), .ack_o(ack[g]), .err_o(err[g]),
      .irq_o(irq[g]), .loc_valid_o(lv[g]), .loc_data_o(ld[g]), .loc_ready_i(lr[g])
    );
  end

  int total = 0, passed = 0;
  logic [6:0] m_ctrl;
  logic [7:0] m_scr;
  bit m_ovf;
  logic [7:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_scr = M_SCR_RST; m_ovf = 0; mq.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the commit edge.
  task automatic xfer(input int d, input bit w, input logic [1:0] a, input logic [7:0] wd,
                      input bit pop, output logic [7:0] rd, output bit ga, output bit ge, output int lat);
    cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; wdat[d] = wd;
    lat = 0; ga = 0; ge = 0; rd = '0;
    while (!(ga || ge) && lat < 40) begin
      @(posedge clk); #1;
      lat++; ga = ack[d]; ge = err[d]; rd = dat_o[d];
    end
    chk("responded", 32'(ga | ge), 1);
    cyc[d] = 0; stb[d] = 0; we[d] = 0;
    if (pop) lr[d] = 1;
    @(posedge clk); #1;
    lr[d] = 0;
    chk("dat_o_idle_zero", dat_o[d], 0);
  endtask

  task automatic m_xfer(input bit w, input logic [1:0] a, input logic [7:0] wd, input bit pop);
    logic [7:0] exp_rd, rd;
    bit ga, ge, exp_err;
    int lat, pre;
    pre = mq.size();
    case (a)
      2'd0: exp_rd = {1'b0, m_ctrl};
      2'd1: exp_rd = {m_ovf, 1'b0, pre == DEPTH, pre == 0, 4'(pre)};
      2'd2: exp_rd = 8'h00;
      default: exp_rd = m_scr;
    endcase
    exp_err = ERR_BUILD && w && a == 2'd2 && pre == DEPTH;
    xfer(MD, w, a, wd, pop, rd, ga, ge, lat);
    chk("term_ack", 32'(ga), 32'(!exp_err));
    chk("term_err", 32'(ge), 32'(exp_err));
    chk("latency", lat, MLAT);
    if (!w) chk($sformatf("rdata_a%0d", a), rd, exp_rd);
    if (pop && m_ctrl[0] && mq.size() > 0) void'(mq.pop_front());
    if (w) begin
      case (a)
        2'd0: begin m_ctrl = wd[6:0]; if (wd[7]) mq.delete(); end
        2'd2: if (pre == DEPTH) m_ovf = 1; else mq.push_back(wd);
        2'd3: m_scr = wd;
        default: ;
      endcase
    end else if (a == 2'd1) m_ovf = 0;
    @(posedge clk); #1;
    chk("irq", irq[MD], 32'(m_ctrl[1] && mq.size() == 0));
    chk("loc_valid", lv[MD], 32'(m_ctrl[0] && mq.size() > 0));
    chk("loc_data", ld[MD], (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
  endtask

  task automatic drain(input int n);
    lr[MD] = 1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", lv[MD], 1);
      chk("drain_data", ld[MD], mq[0]);
      @(posedge clk); #1;
      void'(mq.pop_front());
    end
    lr[MD] = 0;
    chk("drain_after_valid", lv[MD], 32'(m_ctrl[0] && mq.size() > 0));
  endtask

  initial begin
    logic [7:0] rd, d8;
    bit ga, ge, any_ack;
    int lat, n;
    logic [1:0] a;
    m_reset();
    #2;
    chk("rst_ack", ack[MD], 0);
    chk("rst_err", err[MD], 0);
    chk("rst_irq", irq[MD], 0);
    chk("rst_loc_valid", lv[MD], 0);
    chk("rst_loc_data", ld[MD], 0);
    chk("rst_dat_o", dat_o[MD], 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // latency for WAIT_STATES 0 and 3
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1, 2'd3, 8'hA5, 0, rd, ga, ge, lat);
      chk($sformatf("scr_wr_lat_d%0d", d), lat, 32'(WS_TAB[d]) + 1);
      xfer(d, 0, 2'd3, 8'h00, 0, rd, ga, ge, lat);
      chk($sformatf("scr_rd_lat_d%0d", d), lat, 32'(WS_TAB[d]) + 1);
      chk($sformatf("scr_rd_data_d%0d", d), rd, 8'hA5);
    end

    m_xfer(0, 2'd3, 0, 0);              // SCRATCH reset value
    m_xfer(1, 2'd3, 8'hA5, 0);
    m_xfer(0, 2'd3, 0, 0);

    // irq follows irq_en & empty; flush re-raises it
    m_xfer(1, 2'd0, 8'h02, 0);
    m_xfer(1, 2'd2, 8'h11, 0);
    m_xfer(1, 2'd0, 8'h82, 0);
    m_xfer(0, 2'd0, 0, 0);

    // fill, inspect, drain
    m_xfer(1, 2'd0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) m_xfer(1, 2'd2, 8'(i), 0);
    m_xfer(0, 2'd1, 0, 0);
    m_xfer(1, 2'd0, 8'h01, 0);
    drain(4);
    m_xfer(0, 2'd1, 0, 0);

    // overflow, sticky ovf cleared by read
    m_xfer(1, 2'd0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) m_xfer(1, 2'd2, 8'(8'h40 + i), 0);
    m_xfer(1, 2'd2, 8'h99, 0);
    m_xfer(0, 2'd1, 0, 0);
    m_xfer(0, 2'd1, 0, 0);

    // overflow with a pop on the commit edge, then push+pop at half full
    m_xfer(1, 2'd0, 8'h01, 0);
    m_xfer(1, 2'd2, 8'h77, 1);
    m_xfer(0, 2'd1, 0, 0);
    drain(1);
    m_xfer(1, 2'd2, 8'h55, 1);
    m_xfer(0, 2'd1, 0, 0);
    drain(mq.size());

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      a = 2'($urandom_range(3));
      d8 = 8'($urandom);
      if (a == 2'd0 && $urandom_range(3) != 0) d8[7] = 1'b0;
      m_xfer(1'($urandom), a, d8, 1'($urandom));
    end
    n = mq.size();
    m_xfer(1, 2'd0, 8'h01, 0);
    drain(mq.size());
    chk("rand_drained_count", n >= 0, 1);
    m_xfer(0, 2'd1, 0, 0);

    // abandon a SCRATCH write mid-wait
    m_xfer(1, 2'd3, 8'h12, 0);
    cyc[MD] = 1; stb[MD] = 1; we[MD] = 1; adr[MD] = 2'd3; wdat[MD] = 8'h5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[MD] = 0; stb[MD] = 0; we[MD] = 0;
    any_ack = 0;
    for (int i = 0; i < 8; i++) begin
      any_ack |= ack[MD] | err[MD];
      @(posedge clk); #1;
    end
    chk("drop_no_ack", any_ack, 0);
    m_xfer(0, 2'd3, 0, 0);

    // reset while the response is on the bus
    m_xfer(1, 2'd0, 8'h03, 0);
    m_xfer(1, 2'd2, 8'hC3, 0);
    cyc[MD] = 1; stb[MD] = 1; we[MD] = 1; adr[MD] = 2'd3; wdat[MD] = 8'h77;
    n = 0;
    while (!ack[MD] && n < 40) begin @(posedge clk); #1; n++; end
    chk("rst_resp_seen", ack[MD], 1);
    rst_n = 0; #1;
    chk("rst_mid_ack", ack[MD], 0);
    chk("rst_mid_dat_o", dat_o[MD], 0);
    chk("rst_mid_loc_valid", lv[MD], 0);
    chk("rst_mid_loc_data", ld[MD], 0);
    chk("rst_mid_irq", irq[MD], 0);
    cyc[MD] = 0; stb[MD] = 0; we[MD] = 0;
    m_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    m_xfer(0, 2'd3, 0, 0);
    m_xfer(0, 2'd1, 0, 0);
    m_xfer(0, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
